issue_scoreboard: RTL and testbench

- In-order issue controller between the instruction decoder and the execute stage.
- Accepts one decoded instruction at a time, together with the decoder's operand-usage flag.
- Blocks the instruction while any register operand it uses, or its destination, is still pending from an earlier in-flight instruction.
- Also blocks while the in-flight limit is reached. Releases the instruction to execute with a valid/ready handshake.
- Writeback from the back end clears the pending state.

---
 rtl/issue_pkg.sv | 21 ++
 rtl/issue_scoreboard_regs.sv | 62 ++++++
 rtl/issue_scoreboard.sv | 152 +++++++++++++++
 tb/tb_issue_scoreboard.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and field positions for the in-order issue scoreboard.
package issue_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam int FLAG_RD  = 0;
    localparam int FLAG_RS1 = 1;
    localparam int FLAG_RS2 = 2;
    localparam int FLAG_IMM = 3;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    localparam int CNT_W = 4;

endpackage

// File: rtl/issue_scoreboard_regs.sv
// Pending-register bit vector and in-flight counter; exposes the view with the
// same-cycle writeback already applied so the issue decision sees it.
module scoreboard_regs
    import issue_pkg::*;
#(
    parameter int REGISTER_WIDTH = 5,
    parameter int MAX_INFLIGHT   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           set_en,
    input  logic [REGISTER_WIDTH-1:0]      set_idx,
    input  logic                           issue_en,
    input  logic                           clr_en,
    input  logic [REGISTER_WIDTH-1:0]      clr_idx,
    input  logic                           rel_en,
    input  logic                           rel_clr_en,
    input  logic [REGISTER_WIDTH-1:0]      rel_idx,
    output logic [(1<<REGISTER_WIDTH)-1:0] pending_avail,
    output logic                           full
);

    localparam int NREG = 1 << REGISTER_WIDTH;

    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pending_nxt;
    logic [NREG-1:0]  clr_vec;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_avail;
    logic [CNT_W-1:0] inflight_nxt;

    always_comb begin
        clr_vec = '0;
        if (clr_en) clr_vec[clr_idx] = 1'b1;
        pending_avail  = pending & ~clr_vec;
        inflight_avail = inflight - CNT_W'(clr_en && (inflight != '0));
        full           = (inflight_avail == CNT_W'(MAX_INFLIGHT));
    end

    // A new issue setting rd beats a writeback clearing the same rd.
    always_comb begin
        pending_nxt = pending_avail;
        if (rel_clr_en) pending_nxt[rel_idx] = 1'b0;
        if (set_en)     pending_nxt[set_idx] = 1'b1;
        pending_nxt[0] = 1'b0;

        inflight_nxt = inflight_avail;
        if (rel_en && (inflight_nxt != '0)) inflight_nxt = inflight_nxt - CNT_W'(1);
        if (issue_en)                       inflight_nxt = inflight_nxt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            inflight <= '0;
        end else begin
            pending  <= pending_nxt;
            inflight <= inflight_nxt;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue controller: holds one decoded instruction until its operands are free.
// Optional hazard stall counter enabled by defining ISSUE_STALL_COUNTER_EN.
//
// state | meaning
// EMPTY | no instruction held, decoder may hand one over
// CHECK | instruction held, waiting for operands and an in-flight slot
// ISSUE | instruction offered to execute (out_valid high)
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int REGISTER_WIDTH     = 5,
    parameter int FLAG_WIDTH         = 8,
    parameter int MAX_INFLIGHT       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTRUCTION_LENGTH-1:0] in_instruction,
    input  logic [FLAG_WIDTH-1:0]         in_flag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INSTRUCTION_LENGTH-1:0] out_instruction,
    output logic [FLAG_WIDTH-1:0]         out_flag,
    input  logic                          wb_valid,
    input  logic [REGISTER_WIDTH-1:0]     wb_rd,
    input  logic                          flush,
    output logic [31:0]                   stall_cycles
);

    localparam int NREG = 1 << REGISTER_WIDTH;

    state_t                        state;
    logic [INSTRUCTION_LENGTH-1:0] hold_instr;
    logic [FLAG_WIDTH-1:0]         hold_flag;
    logic [NREG-1:0]               pending_avail;
    logic                          full;
    logic                          hazard;
    logic                          issue_go;
    logic                          rel_en;
    logic [REGISTER_WIDTH-1:0]     rd;
    logic [REGISTER_WIDTH-1:0]     rs1;
    logic [REGISTER_WIDTH-1:0]     rs2;
    logic                          writes_rd;

    assign rd        = hold_instr[RD_LSB  +: REGISTER_WIDTH];
    assign rs1       = hold_instr[RS1_LSB +: REGISTER_WIDTH];
    assign rs2       = hold_instr[RS2_LSB +: REGISTER_WIDTH];
    assign writes_rd = hold_flag[FLAG_RD] && (rd != '0);

    assign hazard = (hold_flag[FLAG_RS1] & pending_avail[rs1])
                  | (hold_flag[FLAG_RS2] & pending_avail[rs2])
                  | (hold_flag[FLAG_RD]  & pending_avail[rd])
                  | full;

    assign issue_go = (state == CHECK) && !hazard && !flush;
    assign rel_en   = (state == ISSUE) && flush;

    scoreboard_regs #(
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .MAX_INFLIGHT   (MAX_INFLIGHT)
    ) u_regs (
        .clk           (clk),
        .reset         (reset),
        .set_en        (issue_go && writes_rd),
        .set_idx       (rd),
        .issue_en      (issue_go),
        .clr_en        (wb_valid),
        .clr_idx       (wb_rd),
        .rel_en        (rel_en),
        .rel_clr_en    (rel_en && writes_rd),
        .rel_idx       (rd),
        .pending_avail (pending_avail),
        .full          (full)
    );

    always_comb begin
        in_ready = 1'b0;
        if (!reset && !flush) begin
            case (state)
                EMPTY:   in_ready = 1'b1;
                ISSUE:   in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            hold_instr <= '0;
            hold_flag  <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        hold_instr <= in_instruction;
                        hold_flag  <= in_flag;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (!hazard) begin
                        state     <= ISSUE;
                        out_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            hold_instr <= in_instruction;
                            hold_flag  <= in_flag;
                            state      <= CHECK;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_instruction = hold_instr;
    assign out_flag        = hold_flag;

`ifdef ISSUE_STALL_COUNTER_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state == CHECK) && hazard && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed scenarios plus randomized traffic checked every cycle against a slot/scoreboard model.
module tb_issue_scoreboard;

    localparam int MAXI = 4;
`ifdef ISSUE_STALL_COUNTER_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [7:0]  in_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [7:0]  out_flag;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    issue_scoreboard #(
        .INSTRUCTION_LENGTH (32),
        .REGISTER_WIDTH     (5),
        .FLAG_WIDTH         (8),
        .MAX_INFLIGHT       (MAXI)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_flag         (in_flag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_flag        (out_flag),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .flush           (flush),
        .stall_cycles    (stall_cycles)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a single slot that is empty (0), waiting on operands (1) or offered to execute (2).
    int          m_slot  = 0;
    logic [31:0] m_instr = '0;
    logic [7:0]  m_flag  = '0;
    logic [31:0] m_pend  = '0;
    int          m_cnt   = 0;
    logic [31:0] m_stall = '0;

    function automatic bit blocked(input logic [31:0] pend, input int cnt);
        int r_d, r_s1, r_s2;
        r_d  = int'(m_instr[11:7]);
        r_s1 = int'(m_instr[19:15]);
        r_s2 = int'(m_instr[24:20]);
        return (m_flag[0] && pend[r_d]) || (m_flag[1] && pend[r_s1]) ||
               (m_flag[2] && pend[r_s2]) || (cnt == MAXI);
    endfunction

    always @(negedge clk) begin
        logic [31:0] pend_a;
        int          cnt_a;
        bit          haz;
        int          r_d;
        bit          exp_rdy;

        exp_rdy = !reset && !flush && ((m_slot == 0) || (m_slot == 2 && out_ready));
        chk("in_ready",        in_ready,                 exp_rdy);
        chk("out_valid",       out_valid,                m_slot == 2);
        chk("out_instruction", out_instruction,          m_instr);
        chk("out_flag",        out_flag,                 m_flag);
        chk("stall_cycles",    stall_cycles,             m_stall);
        chk("pending",         dut.u_regs.pending,       m_pend);
        chk("inflight",        32'(dut.u_regs.inflight), m_cnt);

        if (reset) begin
            m_slot = 0; m_instr = '0; m_flag = '0; m_pend = '0; m_cnt = 0; m_stall = '0;
        end else begin
            pend_a = m_pend;
            cnt_a  = m_cnt;
            r_d    = int'(m_instr[11:7]);
            if (wb_valid) begin
                pend_a[wb_rd] = 1'b0;
                if (cnt_a > 0) cnt_a--;
            end
            haz = (m_slot == 1) && blocked(pend_a, cnt_a);
            if (STALL_EN && haz && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (flush) begin
                if (m_slot == 2) begin
                    if (m_flag[0]) pend_a[r_d] = 1'b0;
                    if (cnt_a > 0) cnt_a--;
                end
                m_slot = 0;
            end else if (m_slot == 0) begin
                if (in_valid) begin m_instr = in_instruction; m_flag = in_flag; m_slot = 1; end
            end else if (m_slot == 1) begin
                if (!haz) begin
                    if (m_flag[0]) pend_a[r_d] = 1'b1;
                    cnt_a++;
                    m_slot = 2;
                end
            end else if (out_ready) begin
                if (in_valid) begin m_instr = in_instruction; m_flag = in_flag; m_slot = 1; end
                else m_slot = 0;
            end
            pend_a[0] = 1'b0;
            m_pend = pend_a;
            m_cnt  = cnt_a;
        end
    end

    function automatic logic [31:0] r_op(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] i_op(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic send(input logic [31:0] instr, input logic [7:0] flag);
        in_valid = 1'b1; in_instruction = instr; in_flag = flag;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic do_reset;
        idle;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
        flush = 1'b0; in_instruction = '0; in_flag = '0;
        tick; tick;
        chk("rst_in_ready",  in_ready,                 0);
        chk("rst_out_valid", out_valid,                0);
        chk("rst_pending",   dut.u_regs.pending,       0);
        chk("rst_inflight",  32'(dut.u_regs.inflight), 0);
        chk("rst_stall",     stall_cycles,             0);
        reset = 1'b0;

        // Independent stream
        send(r_op(1, 2, 3), 8'h07);
        chk("ind_lat_n1", out_valid, 0);
        tick;
        chk("ind_ov1", out_valid, 1);
        chk("ind_instr1", out_instruction, r_op(1, 2, 3));
        send(i_op(4, 5, 1), 8'h0B);
        chk("ind_lat_n2", out_valid, 0);
        tick;
        chk("ind_ov2", out_valid, 1);
        chk("ind_instr2", out_instruction, i_op(4, 5, 1));
        tick;
        chk("ind_pending", dut.u_regs.pending, 32'h12);
        chk("ind_inflight", 32'(dut.u_regs.inflight), 2);
        chk("model_pend_pin", m_pend, 32'h12);

        // RAW stall on x1, released by its writeback
        send(r_op(6, 1, 2), 8'h07);
        repeat (3) tick;
        chk("raw_blocked", out_valid, 0);
        chk("raw_stall", stall_cycles, STALL_EN ? 32'd3 : 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd1;
        tick;
        wb_valid = 1'b0;
        chk("raw_ov", out_valid, 1);
        chk("raw_instr", out_instruction, r_op(6, 1, 2));
        chk("raw_pending", dut.u_regs.pending, 32'h50);
        chk("raw_inflight", 32'(dut.u_regs.inflight), 2);
        chk("raw_stall_hold", stall_cycles, STALL_EN ? 32'd3 : 32'd0);
        tick;

        // In-flight limit
        do_reset;
        for (int k = 1; k <= 4; k++) begin
            send(i_op(k, 0, k), 8'h09);
            tick; tick;
        end
        chk("lim_pending", dut.u_regs.pending, 32'h1E);
        chk("model_cnt_pin", 32'(m_cnt), 4);
        send(i_op(5, 0, 5), 8'h09);
        tick; tick;
        chk("lim_blocked", out_valid, 0);
        chk("lim_inflight", 32'(dut.u_regs.inflight), 4);
        wb_valid = 1'b1; wb_rd = 5'd2;
        tick;
        wb_valid = 1'b0;
        chk("lim_release", out_valid, 1);
        chk("lim_inflight2", 32'(dut.u_regs.inflight), 4);
        chk("lim_pending2", dut.u_regs.pending, 32'h3A);
        tick;

        // Register 0 never pending
        do_reset;
        send(i_op(0, 0, 5), 8'h0B);
        tick; tick;
        chk("x0_pending", dut.u_regs.pending, 0);
        chk("x0_inflight", 32'(dut.u_regs.inflight), 1);
        send(r_op(7, 0, 0), 8'h07);
        tick;
        chk("x0_nostall", out_valid, 1);
        chk("x0_pending2", dut.u_regs.pending, 32'h80);
        tick;

        // Backpressure then flush of the held instruction
        do_reset;
        send(r_op(1, 2, 3), 8'h07);
        tick;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("bp_ov", out_valid, 1);
            chk("bp_instr", out_instruction, r_op(1, 2, 3));
        end
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_instruction = i_op(9, 0, 1); in_flag = 8'h09;
        #1;
        chk("fl_in_ready", in_ready, 0);
        tick;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_ov", out_valid, 0);
        chk("fl_pending", dut.u_regs.pending, 0);
        chk("fl_inflight", 32'(dut.u_regs.inflight), 0);
        chk("fl_empty", in_ready, 1);

        // Same-cycle set and clear of x3
        do_reset;
        send(i_op(3, 0, 1), 8'h09);
        tick; tick;
        send(i_op(3, 0, 7), 8'h09);
        tick;
        chk("sc_blocked", out_valid, 0);
        wb_valid = 1'b1; wb_rd = 5'd3;
        tick;
        wb_valid = 1'b0;
        chk("sc_ov", out_valid, 1);
        chk("sc_pending", dut.u_regs.pending, 32'h08);
        chk("sc_inflight", 32'(dut.u_regs.inflight), 1);
        tick;

        // Randomized traffic
        do_reset;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            in_instruction = ins;
            in_flag   = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_rd     = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            tick;
        end
        reset = 1'b0;
        idle;
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
